crossbar_one_hot_pipe_param: RTL and testbench
==============================================

# crossbar_one_hot_pipe_param

Parametrised, fully pipelined one-hot crossbar. It generalises the fixed 16x16 sequential crossbar to any power-of-two input and output count. Each input's data, valid and per-output command bits fan out through a registered binary wire tree. Each output then gathers through a registered binary mux tree that resolves multi-driver conflicts by fixed priority. It sits between the input distribution network and the output collectors wherever a per-cycle, broadcast-capable NxM switch is needed.

## Interface
- DATA_WIDTH, 32: payload width per channel, ≥1.
- NUM_INPUT_DATA, 16: input channel count N, power of 2, 2..64.
- NUM_OUTPUT_DATA, 16: output channel count M, power of 2, 2..64.
- CLK  input  1  clock; all state on rising edge.
- rst  input  1  synchronous active-high reset.
- i_valid  input  N  per-input valid.
- i_data_bus  input  N*DATA_WIDTH  input i at [i*DATA_WIDTH +: DATA_WIDTH].
- i_cmd  input  N*M  one-hot routing; bit i*M+j set = input i drives output j; several bits per input (broadcast) allowed.
- i_en  input  1  global pipeline advance; low = every stage holds.
- o_valid  output  M  per-output valid.
- o_data_bus  output  M*DATA_WIDTH  output j at [j*DATA_WIDTH +: DATA_WIDTH].
- o_conflict  output  M  more than one valid input routed to output j in the same beat.

## Operation
- Fanout: per input, log2(M) registered tree levels carry {valid, data, cmd slice}. The leaf for output j keeps valid and data, plus cmd bit j only.
- Request at leaf (i,j): req = valid_i & cmd[i*M+j].
- Gather: per output, log2(N) registered mux levels. Each node takes two children with (req, data, conflict):
  - req_out = req_lo | req_hi;
  - data_out = req_lo ? data_lo : (req_hi ? data_hi : 0);
  - conflict_out = conflict_lo | conflict_hi | (req_lo & req_hi).
  - "lo" is the lower input index, so the lowest-index requester wins.
- o_valid[j] = root req. o_data_bus lane j = root data, all zeros when o_valid[j] = 0. o_conflict[j] = root conflict.
- A cmd bit with i_valid low generates no request.
- An input with an all-zero cmd slice is dropped silently.
- Broadcast: one input may drive any subset of outputs in the same beat with identical data.

## Timing
- Latency L = log2(M) + log2(N) enabled cycles, input beat to output; 16x16 gives 8.
- Throughput: one beat per enabled cycle; no bubbles.
- i_en low: every register in both trees holds. Outputs are frozen. Inputs presented that cycle are ignored.
- i_en high: every stage advances together. There is no per-channel back-pressure.
- rst high at an edge:
  - All valid, data, cmd and conflict registers clear, regardless of i_en.
  - Outputs read 0 from the next cycle: o_valid = 0, o_data_bus = 0, o_conflict = 0.
  - In-flight beats are discarded.
- First beat after rst deasserts appears L enabled cycles later. No stale data is emitted.
- Conflict is reported in the same cycle as the winning beat. There is no sticky state.

## Configuration
- CROSSBAR_CONFLICT_RESOLVE_EN defined:
  - priority mux and o_conflict logic as above.
- CROSSBAR_CONFLICT_RESOLVE_EN undefined:
  - each mux node ORs (req_lo ? data_lo : 0) | (req_hi ? data_hi : 0);
  - conflict registers are not built and o_conflict is tied 0;
  - software must guarantee at most one requester per output per beat, otherwise the data is the bitwise OR of the colliding inputs.
- Latency and valid behaviour are identical in both builds.

## Test plan
- **Permutation:** 16x16 build; input i sends data 0x100+i with cmd bit i*16+(15-i), i_en=1 → after 8 cycles, output j carries 0x100+(15-j), o_valid = 0xFFFF, o_conflict = 0.
- **Broadcast plus stall:**
  - Input 3 sends 0xCAFE to all outputs; i_en held low for 4 cycles mid-flight.
  - Required: all 16 outputs show 0xCAFE exactly 8 enabled cycles after issue (12 wall cycles).
  - Outputs hold steady while i_en is low.
- **Conflict, resolve build:** inputs 5 and 9 both target output 2 with 0xAA and 0xBB → o_data lane 2 = 0xAA, o_valid[2] = 1, o_conflict[2] = 1, every other o_conflict bit 0.
- **Conflict, resolve undefined:** same stimulus → lane 2 = 0xAA | 0xBB = 0xBB, o_conflict = 0.
- **Reset mid-flight:** issue 3 beats, assert rst for 1 cycle at cycle 4 → all outputs 0 from the next cycle. None of the 3 beats ever appears, and a fresh beat after reset emerges exactly L cycles later.
- **Non-square and gating:** 4x32 build (L = 7) with i_valid=0 and cmd set, then with cmd=0 and i_valid=1 → o_valid stays 0 in both cases. Routing input 2 → output 31 with 0x1234 produces lane 31 = 0x1234 after 7 cycles.

Source files
------------

// File: rtl/crossbar_one_hot_pipe_param.sv
// crossbar_one_hot_pipe_param: pipelined NxM one-hot crossbar (fanout tree then gather tree).
// CROSSBAR_CONFLICT_RESOLVE_EN selects lowest-index priority with o_conflict; undefined ORs colliders.
module crossbar_one_hot_pipe_param #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUT_DATA = 16,
  parameter int NUM_OUTPUT_DATA = 16
) (
  input  logic CLK,
  input  logic rst,
  input  logic [NUM_INPUT_DATA-1:0] i_valid,
  input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] i_data_bus,
  input  logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] i_cmd,
  input  logic i_en,
  output logic [NUM_OUTPUT_DATA-1:0] o_valid,
  output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
  output logic [NUM_OUTPUT_DATA-1:0] o_conflict
);
  localparam int N = NUM_INPUT_DATA;
  localparam int M = NUM_OUTPUT_DATA;
  localparam int DW = DATA_WIDTH;
  localparam int LN = $clog2(N);
  localparam int LM = $clog2(M);
  // Level k holds 2^k copies of valid/data per input; node n owns cmd bits n*(M>>k) +: M>>k, so the cmd layout never changes
  for (genvar k = 0; k <= LM; k++) begin : fo
    logic [N-1:0][(1<<k)-1:0] v;
    logic [N-1:0][(1<<k)-1:0][DW-1:0] d;
    logic [N-1:0][M-1:0] c;
    if (k == 0) begin : g_src
      assign v = i_valid;
      assign d = i_data_bus;
      assign c = i_cmd;
    end else begin : g_reg
      always_ff @(posedge CLK)
        if (rst) begin
          v <= '0;
          d <= '0;
          c <= '0;
        end else if (i_en) begin
          c <= fo[k-1].c;
          for (int i = 0; i < N; i++)
            for (int n = 0; n < (1 << k); n++) begin
              v[i][n] <= fo[k-1].v[i][n>>1];
              d[i][n] <= fo[k-1].d[i][n>>1];
            end
        end
    end
  end
  for (genvar g = 0; g <= LN; g++) begin : ga
    logic [M-1:0][(N>>g)-1:0] r;
    logic [M-1:0][(N>>g)-1:0][DW-1:0] d;
`ifdef CROSSBAR_CONFLICT_RESOLVE_EN
    logic [M-1:0][(N>>g)-1:0] x;
`endif
    if (g == 0) begin : g_leaf
      always_comb begin
`ifdef CROSSBAR_CONFLICT_RESOLVE_EN
        x = '0;
`endif
        r = '0;
        d = '0;
        for (int j = 0; j < M; j++)
          for (int i = 0; i < N; i++) begin
            r[j][i] = fo[LM].v[i][j] & fo[LM].c[i][j];
            d[j][i] = fo[LM].d[i][j];
          end
      end
    end else begin : g_node
      always_ff @(posedge CLK)
        if (rst) begin
          r <= '0;
          d <= '0;
`ifdef CROSSBAR_CONFLICT_RESOLVE_EN
          x <= '0;
`endif
        end else if (i_en) begin
          for (int j = 0; j < M; j++)
            for (int n = 0; n < (N >> g); n++) begin
              r[j][n] <= ga[g-1].r[j][2*n] | ga[g-1].r[j][2*n+1];
`ifdef CROSSBAR_CONFLICT_RESOLVE_EN
              d[j][n] <= ga[g-1].r[j][2*n] ? ga[g-1].d[j][2*n] : ga[g-1].r[j][2*n+1] ? ga[g-1].d[j][2*n+1] : '0;
              x[j][n] <= ga[g-1].x[j][2*n] | ga[g-1].x[j][2*n+1] | (ga[g-1].r[j][2*n] & ga[g-1].r[j][2*n+1]);
`else
              d[j][n] <= (ga[g-1].r[j][2*n] ? ga[g-1].d[j][2*n] : '0) | (ga[g-1].r[j][2*n+1] ? ga[g-1].d[j][2*n+1] : '0);
`endif
            end
        end
    end
  end
  assign o_valid = ga[LN].r;
  assign o_data_bus = ga[LN].d;
`ifdef CROSSBAR_CONFLICT_RESOLVE_EN
  assign o_conflict = ga[LN].x;
`else
  assign o_conflict = '0;
`endif
endmodule

// File: tb/tb_crossbar_one_hot_pipe_param.sv
// tb_crossbar_one_hot_pipe_param: directed plus randomized checks of the crossbar against a delay-line routing model.
module tb_crossbar_one_hot_pipe_param;
  localparam int N = 16, M = 16, DW = 32, L = 8;
`ifdef CROSSBAR_CONFLICT_RESOLVE_EN
  localparam bit RES = 1'b1;
`else
  localparam bit RES = 1'b0;
`endif
  typedef struct packed {
    logic [M-1:0] v;
    logic [M*DW-1:0] d;
    logic [M-1:0] c;
  } beat_t;
  logic CLK = 1'b0, rst = 1'b1, en = 1'b0;
  logic [N-1:0] vin = '0;
  logic [N*DW-1:0] din = '0;
  logic [N*M-1:0] cin = '0;
  logic [M-1:0] vo, co;
  logic [M*DW-1:0] dout;
  logic [3:0] v2 = '0;
  logic [4*DW-1:0] d2 = '0;
  logic [127:0] c2 = '0;
  logic [31:0] vo2, co2;
  logic [32*DW-1:0] dout2;
  int errs = 0, chks = 0;
  beat_t q[$];
  beat_t cur = '0;

  always #5 CLK = ~CLK;

  crossbar_one_hot_pipe_param dut (
    .CLK(CLK), .rst(rst), .i_valid(vin), .i_data_bus(din), .i_cmd(cin), .i_en(en),
    .o_valid(vo), .o_data_bus(dout), .o_conflict(co)
  );
  crossbar_one_hot_pipe_param #(.DATA_WIDTH(32), .NUM_INPUT_DATA(4), .NUM_OUTPUT_DATA(32)) dut2 (
    .CLK(CLK), .rst(rst), .i_valid(v2), .i_data_bus(d2), .i_cmd(c2), .i_en(1'b1),
    .o_valid(vo2), .o_data_bus(dout2), .o_conflict(co2)
  );

  function automatic beat_t route(logic [N-1:0] v, logic [N*DW-1:0] d, logic [N*M-1:0] c);
    beat_t b = '0;
    for (int j = 0; j < M; j++) begin
      int hits;
      hits = 0;
      for (int i = 0; i < N; i++)
        if (v[i] && c[i*M+j]) begin
          if (hits == 0 || !RES) b.d[j*DW +: DW] = b.d[j*DW +: DW] | d[i*DW +: DW];
          hits++;
        end
      b.v[j] = hits > 0;
      b.c[j] = RES && hits > 1;
    end
    return b;
  endfunction

  // A beat accepted on an enabled edge is visible after L-1 further enabled edges
  always @(posedge CLK)
    if (rst) begin
      q.delete();
      for (int k = 0; k < L - 1; k++) q.push_back('0);
      cur <= '0;
    end else if (en) begin
      q.push_back(route(vin, din, cin));
      cur <= q.pop_front();
    end

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; vin = '1; cin = '1; din = '1;
    repeat (2) @(negedge CLK);
    en = 1'b1;
    @(negedge CLK);
    chks++;
    if (vo !== '0 || dout !== '0 || co !== '0 || vo2 !== '0 || dout2 !== '0)
      begin errs++; $display("FAIL reset: v=%h c=%h v2=%h want 0", vo, co, vo2); end
    rst = 1'b0; vin = '0; cin = '0; din = '0;
    for (int t = 1; t <= L + 2; t++) begin
      @(negedge CLK);
      chks++;
      if (vo !== '0 || dout !== '0 || co !== '0)
        begin errs++; $display("FAIL reset_idle t=%0d: v=%h c=%h want 0", t, vo, co); end
    end
  endtask

  task automatic test_permutation;
    en = 1'b1; vin = '1;
    for (int i = 0; i < N; i++) begin
      din[i*DW +: DW] = 32'h100 + i;
      cin[i*M + 15 - i] = 1'b1;
    end
    for (int t = 1; t <= L; t++) begin
      @(negedge CLK);
      vin = '0; din = '0; cin = '0;
      chks++;
      if ({vo, dout, co} !== cur) begin errs++; $display("FAIL perm_model t=%0d: got %h want %h", t, {vo, dout, co}, cur); end
      chks++;
      if (vo !== (t == L ? 16'hFFFF : 16'h0)) begin errs++; $display("FAIL perm_valid t=%0d: got %h", t, vo); end
    end
    for (int j = 0; j < M; j++) begin
      chks++;
      if (dout[j*DW +: DW] !== 32'h100 + 15 - j)
        begin errs++; $display("FAIL perm_lane%0d: got %h want %h", j, dout[j*DW +: DW], 32'h100 + 15 - j); end
    end
    chks++;
    if (co !== '0) begin errs++; $display("FAIL perm_conflict: got %h want 0", co); end
  endtask

  task automatic test_broadcast_stall;
    en = 1'b1; vin = '0; din = '0; cin = '0;
    vin[3] = 1'b1; din[3*DW +: DW] = 32'hCAFE; cin[3*M +: M] = '1;
    for (int t = 1; t <= 12; t++) begin
      @(negedge CLK);
      en = (t >= 3 && t < 7) ? 1'b0 : 1'b1;
      vin = en ? '0 : 16'($urandom);
      din = '0; cin = '0;
      if (!en) for (int i = 0; i < N; i++) begin din[i*DW +: DW] = $urandom; cin[i*M +: M] = 16'($urandom); end
      chks++;
      if ({vo, dout, co} !== cur) begin errs++; $display("FAIL bcast_model t=%0d: got %h want %h", t, {vo, dout, co}, cur); end
      chks++;
      if (vo !== (t == 12 ? 16'hFFFF : 16'h0)) begin errs++; $display("FAIL bcast_valid t=%0d: got %h", t, vo); end
    end
    en = 1'b0; vin = '1; cin = '1;
    for (int t = 0; t < 3; t++) begin
      @(negedge CLK);
      chks++;
      if (vo !== 16'hFFFF || dout !== {16{32'hCAFE}})
        begin errs++; $display("FAIL bcast_hold t=%0d: v=%h d=%h", t, vo, dout); end
    end
    en = 1'b1; vin = '0; cin = '0; din = '0;
  endtask

  task automatic test_conflict;
    en = 1'b1;
    vin[5] = 1'b1; vin[9] = 1'b1;
    din[5*DW +: DW] = 32'hAA; din[9*DW +: DW] = 32'hBB;
    cin[5*M + 2] = 1'b1; cin[9*M + 2] = 1'b1;
    for (int t = 1; t <= L; t++) begin
      @(negedge CLK);
      vin = '0; din = '0; cin = '0;
      chks++;
      if ({vo, dout, co} !== cur) begin errs++; $display("FAIL conf_model t=%0d: got %h want %h", t, {vo, dout, co}, cur); end
    end
    chks++;
    if (dout[2*DW +: DW] !== (RES ? 32'hAA : 32'hBB)) begin errs++; $display("FAIL conf_lane2: got %h", dout[2*DW +: DW]); end
    chks++;
    if (vo !== 16'h0004) begin errs++; $display("FAIL conf_valid: got %h want 0004", vo); end
    chks++;
    if (co !== (RES ? 16'h0004 : 16'h0)) begin errs++; $display("FAIL conf_flag: got %h", co); end
  endtask

  task automatic test_reset_midflight;
    en = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      rst = (t == 4);
      vin = '1;
      for (int i = 0; i < N; i++) begin din[i*DW +: DW] = $urandom; cin[i*M +: M] = 16'($urandom); end
      @(negedge CLK);
    end
    rst = 1'b0; vin = '0; din = '0; cin = '0;
    for (int t = 1; t <= L + 3; t++) begin
      @(negedge CLK);
      chks++;
      if ({vo, dout, co} !== '0) begin errs++; $display("FAIL rst_flush t=%0d: v=%h c=%h want 0", t, vo, co); end
    end
    vin[0] = 1'b1; din[0 +: DW] = 32'h55AA; cin[7] = 1'b1;
    for (int t = 1; t <= L; t++) begin
      @(negedge CLK);
      vin = '0; din = '0; cin = '0;
      chks++;
      if (vo !== (t == L ? 16'h0080 : 16'h0)) begin errs++; $display("FAIL rst_fresh t=%0d: got %h", t, vo); end
    end
    chks++;
    if (dout[7*DW +: DW] !== 32'h55AA) begin errs++; $display("FAIL rst_fresh_lane7: got %h want 55aa", dout[7*DW +: DW]); end
  endtask

  task automatic test_random;
    for (int t = 0; t < 300; t++) begin
      rst = ($urandom_range(0, 49) == 0);
      en = ($urandom_range(0, 3) != 0);
      vin = 16'($urandom);
      for (int i = 0; i < N; i++) din[i*DW +: DW] = $urandom;
      for (int b = 0; b < N*M; b++) cin[b] = ($urandom_range(0, 15) == 0);
      @(negedge CLK);
      chks++;
      if ({vo, dout, co} !== cur) begin errs++; $display("FAIL random t=%0d: got %h want %h", t, {vo, dout, co}, cur); end
    end
    rst = 1'b0; en = 1'b1; vin = '0; din = '0; cin = '0;
  endtask

  task automatic test_nonsquare;
    v2 = '0; c2 = '1; d2 = {4{32'h1234_5678}};
    for (int t = 1; t <= 10; t++) begin
      @(negedge CLK);
      chks++;
      if (vo2 !== '0) begin errs++; $display("FAIL ns_novalid t=%0d: got %h want 0", t, vo2); end
    end
    v2 = '1; c2 = '0;
    for (int t = 1; t <= 10; t++) begin
      @(negedge CLK);
      chks++;
      if (vo2 !== '0) begin errs++; $display("FAIL ns_nocmd t=%0d: got %h want 0", t, vo2); end
    end
    v2 = 4'b0100; c2 = '0; c2[2*32 + 31] = 1'b1; d2 = '0; d2[2*DW +: DW] = 32'h1234;
    for (int t = 1; t <= 7; t++) begin
      @(negedge CLK);
      v2 = '0; c2 = '0; d2 = '0;
      chks++;
      if (vo2 !== (t == 7 ? 32'h8000_0000 : 32'h0)) begin errs++; $display("FAIL ns_route t=%0d: got %h", t, vo2); end
    end
    chks++;
    if (dout2[31*DW +: DW] !== 32'h1234) begin errs++; $display("FAIL ns_lane31: got %h want 1234", dout2[31*DW +: DW]); end
    chks++;
    if (co2 !== '0) begin errs++; $display("FAIL ns_conflict: got %h want 0", co2); end
  endtask

  initial begin
    test_reset;
    test_permutation;
    test_broadcast_stall;
    test_conflict;
    test_reset_midflight;
    test_random;
    test_nonsquare;
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
